// File: rtl/uart_pkg.sv
// UART transmitter shared definitions.
// Parity encodings, FSM states and the default oversampling factor.
package uart_pkg;

    localparam int OVS_DEF = 16;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable baud tick generator.
// Period is final_value+1 clocks; clear realigns the phase to a frame start.
module uart_baud_tick #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] final_value,
    output logic             tick
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_wrap;

    // >= lets a lowered final_value wrap at once instead of running to 2^WIDTH.
    assign w_wrap = (r_cnt >= final_value);
    assign tick   = enable && w_wrap;

    // Count while enabled, restart on clear or after each tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter.
// One frame per valid/ready handshake; back-to-back frames have no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DBIT_MAX = 8,
    parameter int OVS      = OVS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    final_value,
    input  logic                enable,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic [DBIT_MAX-1:0] tx_din,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx,
    output logic                tx_busy,
    output logic                tx_done_tick
);

    localparam int         TW   = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [3:0] DMAX = 4'(DBIT_MAX);

    state_t              r_state;
    logic [TW-1:0]       r_tcnt;
    logic [3:0]          r_bcnt;
    logic [DBIT_MAX-1:0] r_shreg;
    logic [3:0]          r_dbits;
    logic                r_par_en;
    logic                r_par_bit;
    logic                r_stop2;
    logic                r_tx;

    logic                w_tick;
    logic                w_bit_end;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;
    logic [3:0]          w_dbits;
    logic [DBIT_MAX-1:0] w_used;
    logic                w_par;

    uart_baud_tick #(.WIDTH(WIDTH)) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (w_accept),
        .final_value (final_value),
        .tick        (w_tick)
    );

    assign w_bit_end = w_tick && (r_tcnt == TW'(OVS - 1));
    assign w_last    = (r_state == S_STOP) && w_bit_end &&
                       (r_bcnt == {3'b000, r_stop2});
    assign w_ready   = (r_state == S_IDLE) || w_last;
    assign w_accept  = rst_n && tx_valid && w_ready;

    assign w_dbits = ((cfg_dbits < 4'd5) || (cfg_dbits > DMAX)) ?
                     DMAX : cfg_dbits;

    // Parity covers only the data bits that will actually be sent.
    always_comb begin
        w_used = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            w_used[i] = tx_din[i] & (i < int'(w_dbits));
        end
        w_par = (^w_used) ^ (cfg_parity == PAR_ODD);
    end

    // Frame sequencer: latch on accept, step one bit every OVS ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_shreg   <= '0;
            r_dbits   <= DMAX;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else if (w_accept) begin
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
            r_shreg   <= tx_din;
            r_dbits   <= w_dbits;
            r_par_en  <= (cfg_parity == PAR_EVEN) ||
                         (cfg_parity == PAR_ODD);
            r_par_bit <= w_par;
            r_stop2   <= cfg_stop2;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_tcnt <= w_bit_end ? '0 : r_tcnt + 1'b1;
            if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_tx    <= r_shreg[0];
                        r_bcnt  <= '0;
                    end
                    S_DATA: begin
                        if (r_bcnt == r_dbits - 4'd1) begin
                            r_bcnt <= '0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bcnt  <= r_bcnt + 4'd1;
                            r_shreg <= r_shreg >> 1;
                            r_tx    <= r_shreg[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                        r_bcnt  <= '0;
                    end
                    S_STOP: begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bcnt <= r_bcnt + 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx           = r_tx;
    assign tx_ready     = w_ready;
    assign tx_busy      = (r_state != S_IDLE);
    assign tx_done_tick = w_last;

endmodule
